// File: rtl/execute_stage_if.sv
// Decode -> Execute -> WriteBack handshake bundle for the execute stage.
// slave: the execute stage itself. master: the upstream/WB side driving it.
interface execute_stage_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
);
  // decode -> execute
  logic                  datainvx1;
  logic [2:0]            opcodex1;
  logic [DATA_W-1:0]     srcax1;
  logic [DATA_W-1:0]     srcbx1;
  logic [REG_ADDR_W-1:0] dstx1;
  logic                  wr_enx1;
  // execute -> writeback / upstream
  logic                  dataoutvx2;
  logic [DATA_W-1:0]     dataoutx2;
  logic                  wr_enx2;
  logic [REG_ADDR_W-1:0] dstx2;
  logic                  stalled;

  modport slave (
    input  datainvx1, opcodex1, srcax1, srcbx1, dstx1, wr_enx1,
    output dataoutvx2, dataoutx2, wr_enx2, dstx2, stalled
  );

  modport master (
    output datainvx1, opcodex1, srcax1, srcbx1, dstx1, wr_enx1,
    input  dataoutvx2, dataoutx2, wr_enx2, dstx2, stalled
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU ops plus a multi-cycle MUL that stalls
// upstream and sends bubbles to WriteBack while it runs.
module execute_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            internal_reset,
  execute_stage_if.slave  bus
);
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_mul_a;
  logic [DATA_W-1:0]     r_mul_b;
  logic [REG_ADDR_W-1:0] r_mul_dst;
  logic                  r_mul_wr;

  logic                  r_vld;
  logic [DATA_W-1:0]     r_data;
  logic                  r_wr;
  logic [REG_ADDR_W-1:0] r_dst;

  logic [DATA_W-1:0]     w_alu;
  logic [DATA_W-1:0]     w_prod;
  logic                  w_shift_big;
  logic                  w_is_mul;
  logic                  w_stalled;

  assign w_is_mul    = bus.datainvx1 && (bus.opcodex1 == OP_MUL);
  // Shift amount is the whole operand; anything past the word width clears it.
  assign w_shift_big = (bus.srcbx1 >= DATA_W'(DATA_W));
  // Unsigned product truncated to the result width.
  assign w_prod      = r_mul_a * r_mul_b;

  // Single-cycle ALU result for the instruction currently presented.
  always_comb begin
    w_alu = '0;
    case (bus.opcodex1)
      OP_ADD: w_alu = bus.srcax1 + bus.srcbx1;
      OP_SUB: w_alu = bus.srcax1 - bus.srcbx1;
      OP_AND: w_alu = bus.srcax1 & bus.srcbx1;
      OP_OR:  w_alu = bus.srcax1 | bus.srcbx1;
      OP_XOR: w_alu = bus.srcax1 ^ bus.srcbx1;
      OP_SHL: w_alu = w_shift_big ? '0 : (bus.srcax1 << bus.srcbx1);
      OP_SHR: w_alu = w_shift_big ? '0 : (bus.srcax1 >> bus.srcbx1);
      default: w_alu = '0;
    endcase
  end

  // Hold upstream while a MUL is accepted or running; release in the last
  // BUSY cycle so upstream advances on the same edge the product lands.
  always_comb begin
    w_stalled = 1'b0;
    if (reset || internal_reset) w_stalled = 1'b0;
    else if (r_state == IDLE)    w_stalled = w_is_mul;
    else                         w_stalled = (r_cnt > CNT_W'(1));
  end

  // EX->WB pipeline register and MUL sequencing FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_mul_dst <= '0;
      r_mul_wr  <= 1'b0;
      r_vld     <= 1'b0;
      r_data    <= '0;
      r_wr      <= 1'b0;
      r_dst     <= '0;
    end else if (internal_reset) begin
      // Flush beats everything, including a MUL finishing this edge.
      r_state <= IDLE;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_is_mul) begin
            r_mul_a   <= bus.srcax1;
            r_mul_b   <= bus.srcbx1;
            r_mul_dst <= bus.dstx1;
            r_mul_wr  <= bus.wr_enx1;
            r_cnt     <= CNT_W'(MUL_CYCLES - 1);
            r_state   <= BUSY;
            r_vld     <= 1'b0;
            r_wr      <= 1'b0;
          end else if (bus.datainvx1) begin
            r_data <= w_alu;
            r_dst  <= bus.dstx1;
            r_vld  <= 1'b1;
            r_wr   <= bus.wr_enx1;
          end else begin
            r_vld <= 1'b0;
            r_wr  <= 1'b0;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_data  <= w_prod;
            r_dst   <= r_mul_dst;
            r_vld   <= 1'b1;
            r_wr    <= r_mul_wr;
            r_state <= IDLE;
          end else begin
            r_vld <= 1'b0;
            r_wr  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dataoutvx2 = r_vld;
  assign bus.dataoutx2  = r_data;
  assign bus.wr_enx2    = r_wr;
  assign bus.dstx2      = r_dst;
  assign bus.stalled    = w_stalled;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: stimulus pushes hand-computed results into a
// scoreboard queue; a monitor pops and compares on every valid WB beat.
module tb_execute_stage;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int MC = 4;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

  logic clk = 1'b0;
  logic reset;
  logic internal_reset;

  execute_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

  execute_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .MUL_CYCLES(MC)) dut (
    .clk            (clk),
    .reset          (reset),
    .internal_reset (internal_reset),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] dst;
    logic          wr;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [AW-1:0] dst, input logic wr);
    bus.datainvx1 = v;
    bus.opcodex1  = op;
    bus.srcax1    = a;
    bus.srcbx1    = b;
    bus.dstx1     = dst;
    bus.wr_enx1   = wr;
  endtask

  task automatic idle();
    drive(1'b0, ADD, '0, '0, '0, 1'b0);
  endtask

  // Present an instruction and record the result WB must eventually see.
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [AW-1:0] dst, input logic wr, input logic [DW-1:0] exp);
    exp_t e;
    drive(1'b1, op, a, b, dst, wr);
    e.data = exp; e.dst = dst; e.wr = wr;
    sb.push_back(e);
  endtask

  // MUL presented this cycle and held by upstream while stalled; returns at
  // the negedge of the final BUSY cycle (cycle MC-1).
  task automatic mul_run(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] dst, input logic [DW-1:0] exp);
    issue(MUL, a, b, dst, 1'b1, exp);
    #1 chk("mul_c0_stalled", bus.stalled, 1);
    for (int k = 1; k < MC; k++) begin
      cyc();
      #1 chk($sformatf("mul_c%0d_stalled", k), bus.stalled, (k <= MC - 2) ? 1 : 0);
      @(negedge clk);
      chk($sformatf("mul_c%0d_bubble", k), bus.dataoutvx2, 0);
    end
  endtask

  // Scoreboard monitor: every valid WB beat must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.dataoutvx2) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL wb_unexpected: got data %0h dst %0d with nothing expected @%0t",
                   bus.dataoutx2, bus.dstx2, $time);
        end else begin
          e = sb.pop_front();
          chk("wb_data", bus.dataoutx2, e.data);
          chk("wb_dst",  bus.dstx2,     e.dst);
          chk("wb_wr",   bus.wr_enx2,   e.wr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    internal_reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld",   bus.dataoutvx2, 0);
    chk("rst_data",  bus.dataoutx2,  0);
    chk("rst_dst",   bus.dstx2,      0);
    chk("rst_wr",    bus.wr_enx2,    0);
    chk("rst_stall", bus.stalled,    0);
    cyc(); reset = 1'b0;

    // 1. Reset in the middle of a MUL
    cyc(); issue(ADD, 16'd5, 16'd6, 3'd3, 1'b1, 16'h000B);
    cyc(); drive(1'b1, MUL, 16'd2, 16'd3, 3'd1, 1'b1);
    cyc();
    cyc();
    #1 reset = 1'b1;
    #1;
    chk("amid_vld",   bus.dataoutvx2, 0);
    chk("amid_data",  bus.dataoutx2,  0);
    chk("amid_dst",   bus.dstx2,      0);
    chk("amid_wr",    bus.wr_enx2,    0);
    chk("amid_stall", bus.stalled,    0);
    idle();
    #1 reset = 1'b0;
    cyc(); issue(ADD, 16'd3, 16'd4, 3'd2, 1'b1, 16'd7);
    cyc(); idle();
    @(negedge clk);
    chk("add_vld", bus.dataoutvx2, 1);

    // 2. Wrap and shift corners, back-to-back with no stall
    cyc(); issue(ADD, 16'hFFFF, 16'h0001, 3'd1, 1'b1, 16'h0000);
    #1 chk("b2b_stall0", bus.stalled, 0);
    cyc(); issue(SUB, 16'h0000, 16'h0001, 3'd2, 1'b1, 16'hFFFF);
    #1 chk("b2b_stall1", bus.stalled, 0);
    cyc(); issue(SHL, 16'h0001, 16'd15, 3'd3, 1'b1, 16'h8000);
    cyc(); issue(SHR, 16'h8000, 16'd16, 3'd4, 1'b1, 16'h0000);
    cyc(); issue(AND_, 16'hF0F0, 16'h0FF0, 3'd5, 1'b1, 16'h00F0);
    cyc(); issue(OR_, 16'hF0F0, 16'h0FF0, 3'd6, 1'b0, 16'hFFF0);
    cyc(); issue(SHL, 16'h0001, 16'd16, 3'd7, 1'b1, 16'h0000);
    cyc(); idle();

    // 3. MUL 300*300 = 0x15F90 -> 0x5F90
    cyc(); mul_run(16'd300, 16'd300, 3'd5, 16'h5F90);
    cyc(); idle();
    @(negedge clk);
    chk("mul_c4_vld",  bus.dataoutvx2, 1);
    chk("mul_c4_data", bus.dataoutx2,  16'h5F90);

    // 4. ADD, MUL, XOR back-to-back
    cyc(); issue(ADD, 16'd1, 16'd2, 3'd1, 1'b1, 16'd3);
    cyc(); mul_run(16'd7, 16'd9, 3'd4, 16'd63);
    cyc(); issue(XOR_, 16'hF0F0, 16'h0FF0, 3'd6, 1'b1, 16'hFF00);
    #1 chk("xor_issue_stall", bus.stalled, 0);
    @(negedge clk);
    chk("b2b_mul_data", bus.dataoutx2, 16'd63);
    cyc(); idle();
    @(negedge clk);
    chk("b2b_xor_vld",  bus.dataoutvx2, 1);
    chk("b2b_xor_data", bus.dataoutx2,  16'hFF00);
    cyc();
    @(negedge clk);
    chk("b2b_no_dup", bus.dataoutvx2, 0);

    // 5. Flush in cycle 2 of a MUL: no result may ever appear
    cyc(); drive(1'b1, MUL, 16'd5, 16'd5, 3'd2, 1'b1);
    #1 chk("fl_c0_stall", bus.stalled, 1);
    cyc();
    cyc(); internal_reset = 1'b1;
    #1 chk("fl_c2_stall", bus.stalled, 0);
    cyc(); internal_reset = 1'b0; idle();
    #1 chk("fl_c3_stall", bus.stalled, 0);
    @(negedge clk);
    chk("fl_c3_vld", bus.dataoutvx2, 0);
    repeat (6) cyc();
    issue(ADD, 16'd10, 16'd20, 3'd7, 1'b1, 16'h001E);
    #1 chk("fl_idle_stall", bus.stalled, 0);
    cyc(); idle();
    @(negedge clk);
    chk("fl_idle_vld", bus.dataoutvx2, 1);

    // 6. Invalid input with wr_en set: bubble, data holds
    cyc(); drive(1'b0, ADD, 16'h1234, 16'h0001, 3'd5, 1'b1);
    cyc(); idle();
    @(negedge clk);
    chk("inv_vld",  bus.dataoutvx2, 0);
    chk("inv_wr",   bus.wr_enx2,    0);
    chk("inv_data", bus.dataoutx2,  16'h001E);
    chk("inv_dst",  bus.dstx2,      3'd7);

    repeat (3) cyc();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
